tx_arbiter: RTL and testbench

Shares the single UART transmitter between up to `NREQ` byte sources: screen refresh, cursor echo and escape-sequence generation. Each requester streams bytes as a packet ending in a `last` flag. The arbiter grants one requester at a time, round-robin at packet boundaries, so escape sequences are never interleaved. It sits between the terminal-side byte producers and the UART TX, driving the same `o_byte` / `o_byte_v` / `i_tx_active` / `i_tx_done` handshake the TX already expects.

---
 rtl/term_pkg.sv | 19 +
 rtl/tx_arbiter_if.sv | 27 ++
 rtl/tx_arbiter_picker.sv | 38 +++
 rtl/tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_tx_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/term_pkg.sv
// Shared terminal-side types: arbiter FSM states, escape-sequence byte constants, default sizing.
// Pure declarations; no latency or backpressure of its own.
package term_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4
  } arb_state_e;

  localparam logic [7:0] ESC         = 8'h1B;
  localparam logic [7:0] CSI_BRACKET = 8'h5B;

  localparam int NREQ_DEFAULT         = 4;
  localparam int HOLD_TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/tx_arbiter_if.sv
// Byte-source and UART-TX handshake bundle for tx_arbiter; slave is the arbiter side.
// Requesters hold byte/last while valid until acked; the TX start pulse waits for an idle transmitter.
interface tx_arbiter_if #(
  parameter int NREQ = term_pkg::NREQ_DEFAULT
);
  logic [NREQ-1:0]   i_req_v;
  logic [8*NREQ-1:0] i_req_byte;
  logic [NREQ-1:0]   i_req_last;
  logic [NREQ-1:0]   o_req_ack;
  logic [NREQ-1:0]   o_grant;
  logic [7:0]        o_byte;
  logic              o_byte_v;
  logic              i_tx_active;
  logic              i_tx_done;
  logic              o_busy;
  logic              o_timeout;

  modport master (
    output i_req_v, i_req_byte, i_req_last, i_tx_active, i_tx_done,
    input  o_req_ack, o_grant, o_byte, o_byte_v, o_busy, o_timeout
  );

  modport slave (
    input  i_req_v, i_req_byte, i_req_last, i_tx_active, i_tx_done,
    output o_req_ack, o_grant, o_byte, o_byte_v, o_busy, o_timeout
  );
endinterface

// File: rtl/tx_arbiter_picker.sv
// Round-robin pick: first valid index at or above ptr, else lowest valid (wrap). Combinational.
// No handshake; the caller decides when the pick is consumed.
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] upper_mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] cand;

  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper_mask[i] = (IW'(i) >= ptr_i);
    end
    masked = valid_i & upper_mask;
    // Nothing at or above the pointer: wrap to the full vector.
    cand   = (|masked) ? masked : valid_i;
    pick_o = '0;
    idx_o  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_o    = '0;
        pick_o[i] = 1'b1;
        idx_o     = IW'(i);
      end
    end
    any_o = |valid_i;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-granular round-robin share of one UART TX among NREQ byte sources; grant 1 cycle after request, byte+ack 2, start pulse 3.
// A requester holds its byte until acked; start pulse waits while TX is active; an owner idle mid-packet loses the grant after HOLD_TIMEOUT.
module tx_arbiter
  import term_pkg::*;
#(
  parameter int NREQ         = NREQ_DEFAULT,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            last_q, last_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_v_q, byte_v_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            owner_v;
  logic [7:0]      owner_byte;
  logic            owner_last;
  logic [CW-1:0]   cnt_inc;
  logic            hold_expired;
  logic [IW-1:0]   ptr_after_owner;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid_i (bus.i_req_v),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign owner_v    = bus.i_req_v[owner_q];
  assign owner_byte = bus.i_req_byte[{owner_q, 3'b000} +: 8];
  assign owner_last = bus.i_req_last[owner_q];

  // Saturating so a stuck HOLD can never wrap back below the threshold.
  assign cnt_inc         = (cnt_q == CW'(HOLD_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
  assign hold_expired    = (cnt_inc == CW'(HOLD_TIMEOUT));
  assign ptr_after_owner = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      byte_q    <= '0;
      byte_v_q  <= 1'b0;
      ack_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      byte_q    <= byte_d;
      byte_v_q  <= byte_v_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_LOAD;
      ST_LOAD: state_d = owner_v ? ST_SEND : ST_HOLD;
      ST_SEND: if (!bus.i_tx_active) state_d = ST_WAIT;
      ST_WAIT: if (bus.i_tx_done) state_d = last_q ? ST_IDLE : ST_HOLD;
      ST_HOLD: begin
        if (owner_v)           state_d = ST_LOAD;
        else if (hold_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    byte_d    = byte_q;
    byte_v_d  = 1'b0;
    ack_d     = '0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (owner_v) begin
          byte_d = owner_byte;
          ack_d  = grant_q;
          last_d = owner_last;
        end
      end
      ST_SEND: begin
        if (!bus.i_tx_active) byte_v_d = 1'b1;
      end
      ST_WAIT: begin
        if (bus.i_tx_done && last_q) begin
          grant_d = '0;
          ptr_d   = ptr_after_owner;
        end
      end
      ST_HOLD: begin
        if (owner_v) begin
          cnt_d = '0;
        end else if (hold_expired) begin
          grant_d   = '0;
          ptr_d     = ptr_after_owner;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_grant   = grant_q;
  assign bus.o_req_ack = ack_q;
  assign bus.o_byte    = byte_q;
  assign bus.o_byte_v  = byte_v_q;
  assign bus.o_timeout = timeout_q;
  assign bus.o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboarded bench for tx_arbiter: packet-level round-robin model feeds expected bytes, a negedge monitor checks them.
module tb_tx_arbiter;
  import term_pkg::*;

  localparam int N  = 4;
  localparam int HT = 40;

  typedef struct {
    logic [7:0] dat;
    logic       last;
    int         gap;
  } item_t;

  typedef struct {
    logic [7:0] dat;
    int         src;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_arbiter_if #(.NREQ(N)) bus ();

  tx_arbiter #(.NREQ(N), .HOLD_TIMEOUT(HT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  item_t rq[N][$];
  item_t mq[N][$];
  exp_t  exp_q[$];
  exp_t  e;
  int    gap_cnt[N];
  logic [N-1:0] ack_seen = '0;

  int nchk = 0, nbad = 0;
  int cyc = 0;
  int mdl_ptr = 0;
  int exp_acks = 0, got_acks = 0, exp_to = 0, got_to = 0, got_bv = 0;
  int tx_lat = 10, tx_cnt = 0;
  logic tx_busy = 1'b0, bv_seen = 1'b0, force_act = 1'b0, rand_lat = 1'b0;
  logic chk_timing = 1'b0, first_bv = 1'b0, chk_fall = 1'b0, prev_bv = 1'b0;
  logic [N-1:0] prev_grant = '0;
  int req_cyc = 0, g_rise = 0, last_done = 0, fall_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    nchk++;
    if (act != req) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Requester and UART TX models.
  initial begin
    forever begin
      logic idle_before;
      @(posedge clk);
      #1;
      if (rst_n) begin
        idle_before = (bus.i_req_v == '0);
        for (int k = 0; k < N; k++) begin
          if (ack_seen[k]) begin
            ack_seen[k]    = 1'b0;
            bus.i_req_v[k] = 1'b0;
            if (rq[k].size() > 0) rq[k].delete(0);
            gap_cnt[k] = (rq[k].size() > 0) ? rq[k][0].gap : 0;
          end
          if (!bus.i_req_v[k] && rq[k].size() > 0) begin
            if (gap_cnt[k] == 0) begin
              bus.i_req_v[k]           = 1'b1;
              bus.i_req_byte[8*k +: 8] = rq[k][0].dat;
              bus.i_req_last[k]        = rq[k][0].last;
              if (idle_before) req_cyc = cyc;
            end else begin
              gap_cnt[k]--;
            end
          end
        end
        bus.i_tx_done = 1'b0;
        if (bv_seen) begin
          bv_seen = 1'b0;
          tx_busy = 1'b1;
          tx_cnt  = (rand_lat ? int'($urandom_range(12, 2)) : tx_lat) - 1;
        end else if (tx_busy) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            tx_busy       = 1'b0;
            bus.i_tx_done = 1'b1;
          end
        end
        bus.i_tx_active = tx_busy | force_act;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_byte_v) begin
        got_bv++;
        bv_seen = 1'b1;
        check("bv_back_to_back", int'(prev_bv), 0);
        check("bv_while_active", int'(bus.i_tx_active), 0);
        if (exp_q.size() == 0) begin
          nchk++;
          nbad++;
          $display("FAIL unexpected_byte: got %0h want none", bus.o_byte);
        end else begin
          e = exp_q.pop_front();
          check("byte", int'(bus.o_byte), int'(e.dat));
          check("byte_owner", int'(bus.o_grant), 1 << e.src);
        end
        if (chk_timing) begin
          if (first_bv) begin
            check("req_to_grant", g_rise - req_cyc, 1);
            check("grant_to_bv", cyc - g_rise, 2);
            first_bv = 1'b0;
          end else begin
            check("done_to_bv", cyc - last_done, 4);
          end
        end
        if (chk_fall) begin
          check("active_fall_to_bv", cyc - fall_cyc, 1);
          chk_fall = 1'b0;
        end
      end
      if (bus.o_req_ack != '0) begin
        got_acks++;
        if (exp_q.size() == 0) begin
          nchk++;
          nbad++;
          $display("FAIL unexpected_ack: got %0h want none", bus.o_req_ack);
        end else begin
          check("ack_owner", int'(bus.o_req_ack), 1 << exp_q[0].src);
        end
        ack_seen = ack_seen | bus.o_req_ack;
      end
      if (bus.o_timeout) begin
        got_to++;
        check("timeout_delay", cyc - last_done, HT + 1);
        check("timeout_grant", int'(bus.o_grant), 0);
      end
      if (bus.i_tx_done) last_done = cyc;
      if (bus.o_grant != '0 && prev_grant == '0) g_rise = cyc;
      prev_bv    = bus.o_byte_v;
      prev_grant = bus.o_grant;
    end
  end

  task automatic add_byte(input int k, input logic [7:0] d, input logic last, input int gap);
    item_t it;
    it.dat  = d;
    it.last = last;
    it.gap  = gap;
    if (rq[k].size() == 0) gap_cnt[k] = gap;
    rq[k].push_back(it);
    mq[k].push_back(it);
  endtask

  // Packet-level reference: round-robin over requesters with queued bytes,
  // a whole packet per grant, a packet without last ends in a forced release.
  task automatic run_model();
    forever begin
      int    k;
      item_t it;
      k = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (mdl_ptr + i) % N;
        if (k < 0 && mq[c].size() > 0) k = c;
      end
      if (k < 0) break;
      do begin
        it = mq[k].pop_front();
        exp_q.push_back('{dat: it.dat, src: k});
        exp_acks++;
      end while (!it.last && mq[k].size() > 0);
      if (!it.last) exp_to++;
      mdl_ptr = (k + 1) % N;
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pending() || bus.i_req_v != '0 || bus.o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_in_budget"}, int'(n < budget), 1);
    repeat (2) @(negedge clk);
    check({name, "_idle_grant"}, int'(bus.o_grant), 0);
    check({name, "_acks"}, got_acks, exp_acks);
    check({name, "_timeouts"}, got_to, exp_to);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_grant"},   int'(bus.o_grant), 0);
    check({name, "_ack"},     int'(bus.o_req_ack), 0);
    check({name, "_byte"},    int'(bus.o_byte), 0);
    check({name, "_byte_v"},  int'(bus.o_byte_v), 0);
    check({name, "_busy"},    int'(bus.o_busy), 0);
    check({name, "_timeout"}, int'(bus.o_timeout), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv0, n;
    rst_n           = 1'b0;
    bus.i_req_v     = '0;
    bus.i_req_byte  = '0;
    bus.i_req_last  = '0;
    bus.i_tx_active = 1'b0;
    bus.i_tx_done   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention between 0 and 2 from pointer 0: packets alternate 0,2,0,2.
    add_byte(0, 8'h10, 1'b0, 0); add_byte(0, 8'h11, 1'b1, 0);
    add_byte(0, 8'h12, 1'b0, 0); add_byte(0, 8'h13, 1'b1, 0);
    add_byte(2, 8'h20, 1'b0, 0); add_byte(2, 8'h21, 1'b1, 0);
    add_byte(2, 8'h22, 1'b0, 0); add_byte(2, 8'h23, 1'b1, 0);
    run_model();
    drain("contention", 3000);

    // Single escape sequence with a fixed 10-cycle TX; cycle-exact timing.
    chk_timing = 1'b1;
    first_bv   = 1'b1;
    tx_lat     = 10;
    add_byte(0, ESC, 1'b0, 0);
    add_byte(0, CSI_BRACKET, 1'b0, 0);
    add_byte(0, 8'h48, 1'b1, 0);
    run_model();
    drain("esc_seq", 3000);
    chk_timing = 1'b0;

    // Requester 1 abandons its packet; forced release, then requester 3.
    add_byte(1, 8'h41, 1'b0, 0);
    add_byte(3, 8'h33, 1'b0, 0);
    add_byte(3, 8'h34, 1'b1, 0);
    run_model();
    drain("hold_timeout", 3000);

    // TX busy for a long stretch while the arbiter sits in SEND.
    @(posedge clk);
    #2;
    force_act       = 1'b1;
    bus.i_tx_active = 1'b1;
    bv0 = got_bv;
    add_byte(2, 8'h55, 1'b1, 0);
    run_model();
    n = 0;
    while (bus.o_grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_tx_grant_wait", int'(n < 50), 1);
    repeat (22) @(negedge clk);
    check("busy_tx_no_start", got_bv - bv0, 0);
    @(posedge clk);
    #2;
    force_act       = 1'b0;
    bus.i_tx_active = tx_busy;
    fall_cyc        = cyc;
    chk_fall        = 1'b1;
    drain("busy_tx", 3000);

    // Asynchronous reset while waiting for the second byte of a packet.
    bv0 = got_bv;
    add_byte(2, 8'h61, 1'b0, 0);
    add_byte(2, 8'h62, 1'b0, 0);
    add_byte(2, 8'h63, 1'b1, 0);
    run_model();
    n = 0;
    while (got_bv - bv0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_wait_reached", int'(n < 200), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    for (int k = 0; k < N; k++) begin
      rq[k].delete();
      mq[k].delete();
      gap_cnt[k] = 0;
    end
    exp_q.delete();
    ack_seen        = '0;
    bus.i_req_v     = '0;
    bus.i_req_last  = '0;
    bus.i_tx_done   = 1'b0;
    bus.i_tx_active = 1'b0;
    tx_busy  = 1'b0;
    tx_cnt   = 0;
    bv_seen  = 1'b0;
    prev_bv  = 1'b0;
    prev_grant = '0;
    mdl_ptr  = 0;
    exp_acks = 0; got_acks = 0; exp_to = 0; got_to = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    add_byte(3, 8'h70, 1'b1, 0);
    add_byte(2, 8'h61, 1'b0, 0);
    add_byte(2, 8'h62, 1'b0, 0);
    add_byte(2, 8'h63, 1'b1, 0);
    run_model();
    drain("after_reset", 3000);

    // Randomized traffic: all requesters start together, gaps only mid-packet.
    rand_lat = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        int npk;
        npk = $urandom_range(3, 0);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) begin
            add_byte(k, 8'($urandom), (b == len - 1), (b == 0) ? 0 : int'($urandom_range(5, 0)));
          end
        end
      end
      run_model();
      drain("random", 8000);
    end

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
